// File: rtl/l2_mem_arbiter.sv
// ---------------------------------------------------------------------------
// l2_mem_arbiter
// Bus arbiter that lets one of two private L2 caches at a time own the shared
// main-memory bus. The granted cache's address/rw are latched onto the memory
// side, write data is driven onto the bidirectional memory data bus, and read
// data is returned to the granted cache with a one-cycle RDY pulse.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   data_in_x  / data_out_x    write data from / read data to cache x (x=1,2)
//   addr_x, rw_x, ce_x         request from cache x (rw 1=read, 0=write)
//   pro_x                      grant: cache x owns the memory bus
//   RDY_x                      one-cycle completion pulse to cache x
//   data_low                   memory data bus (driven only for a granted write)
//   addr_low, rw_low, ce_low   memory request
//   RDY_low                    memory done (OR of both bank RDYs)
//
// Configuration
//   ARB_ROUND_ROBIN_EN  defined:   ties go to the port not served last
//                       undefined: fixed priority, port 1 wins ties
// ---------------------------------------------------------------------------
module l2_mem_arbiter #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in_1,
  output logic [DATA_W-1:0] data_out_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic              rw_1,
  input  logic              ce_1,
  output logic              pro_1,
  output logic              RDY_1,
  input  logic [DATA_W-1:0] data_in_2,
  output logic [DATA_W-1:0] data_out_2,
  input  logic [ADDR_W-1:0] addr_2,
  input  logic              rw_2,
  input  logic              ce_2,
  output logic              pro_2,
  output logic              RDY_2,
  inout  wire  [DATA_W-1:0] data_low,
  output logic [ADDR_W-1:0] addr_low,
  output logic              rw_low,
  input  logic              RDY_low,
  output logic              ce_low
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic sel_q, sel_d;    // owner of the bus: 0 = port 1, 1 = port 2
  logic last_q, last_d;  // last completed owner: 0 = port 1, 1 = port 2

  logic pro_1_q, pro_1_d;
  logic pro_2_q, pro_2_d;
  logic rdy_1_q, rdy_1_d;
  logic rdy_2_q, rdy_2_d;
  logic ce_low_q, ce_low_d;
  logic rw_low_q, rw_low_d;
  logic drive_q, drive_d;

  logic [ADDR_W-1:0] addr_low_q, addr_low_d;
  logic [DATA_W-1:0] dout_1_q, dout_1_d;
  logic [DATA_W-1:0] dout_2_q, dout_2_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic tie_pick_2_c;
  logic pick_2_c;
  logic ce_sel_c;
  logic abort_c;

  // Tie-break selection between simultaneous requests
`ifdef ARB_ROUND_ROBIN_EN
  assign tie_pick_2_c = ~last_q;
`else
  logic unused_last;
  assign tie_pick_2_c = 1'b0;
  assign unused_last  = last_q;
`endif

  assign pick_2_c = ce_2 & (~ce_1 | tie_pick_2_c);

  // Request line of whichever port currently owns the bus
  assign ce_sel_c = sel_q ? ce_2 : ce_1;

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    pro_1_d    = pro_1_q;
    pro_2_d    = pro_2_q;
    rdy_1_d    = 1'b0;
    rdy_2_d    = 1'b0;
    ce_low_d   = ce_low_q;
    rw_low_d   = rw_low_q;
    drive_d    = drive_q;
    addr_low_d = addr_low_q;
    dout_1_d   = dout_1_q;
    dout_2_d   = dout_2_q;
    wdata_d    = wdata_q;
    abort_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ce_1 | ce_2) begin
          sel_d      = pick_2_c;
          pro_1_d    = ~pick_2_c;
          pro_2_d    = pick_2_c;
          addr_low_d = pick_2_c ? addr_2 : addr_1;
          rw_low_d   = pick_2_c ? rw_2 : rw_1;
          wdata_d    = pick_2_c ? data_in_2 : data_in_1;
          drive_d    = ~(pick_2_c ? rw_2 : rw_1);
          ce_low_d   = 1'b1;
          state_d    = S_GRANT;
        end
      end

      // One setup cycle for memory before RDY_low is looked at
      S_GRANT: begin
        if (!ce_sel_c) abort_c = 1'b1;
        else           state_d = S_WAIT;
      end

      S_WAIT: begin
        if (!ce_sel_c) begin
          abort_c = 1'b1;
        end else if (RDY_low) begin
          if (rw_low_q) begin
            if (sel_q) dout_2_d = data_low;
            else       dout_1_d = data_low;
          end
          ce_low_d = 1'b0;
          rdy_1_d  = ~sel_q;
          rdy_2_d  = sel_q;
          state_d  = S_DONE;
        end
      end

      // Hold the grant until the owner drops ce so a request is served once
      S_DONE: begin
        if (!ce_sel_c) begin
          pro_1_d = 1'b0;
          pro_2_d = 1'b0;
          drive_d = 1'b0;
          last_d  = sel_q;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (abort_c) begin
      ce_low_d = 1'b0;
      drive_d  = 1'b0;
      pro_1_d  = 1'b0;
      pro_2_d  = 1'b0;
      state_d  = S_IDLE;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;
      pro_1_q    <= 1'b0;
      pro_2_q    <= 1'b0;
      rdy_1_q    <= 1'b0;
      rdy_2_q    <= 1'b0;
      ce_low_q   <= 1'b0;
      rw_low_q   <= 1'b1;
      drive_q    <= 1'b0;
      addr_low_q <= '0;
      dout_1_q   <= '0;
      dout_2_q   <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      pro_1_q    <= pro_1_d;
      pro_2_q    <= pro_2_d;
      rdy_1_q    <= rdy_1_d;
      rdy_2_q    <= rdy_2_d;
      ce_low_q   <= ce_low_d;
      rw_low_q   <= rw_low_d;
      drive_q    <= drive_d;
      addr_low_q <= addr_low_d;
      dout_1_q   <= dout_1_d;
      dout_2_q   <= dout_2_d;
      wdata_q    <= wdata_d;
    end
  end

  assign pro_1      = pro_1_q;
  assign pro_2      = pro_2_q;
  assign RDY_1      = rdy_1_q;
  assign RDY_2      = rdy_2_q;
  assign ce_low     = ce_low_q;
  assign rw_low     = rw_low_q;
  assign addr_low   = addr_low_q;
  assign data_out_1 = dout_1_q;
  assign data_out_2 = dout_2_q;

  // Bus is released whenever no granted write is in flight
  assign data_low = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_l2_mem_arbiter.sv
module tb_l2_mem_arbiter;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 64;
  localparam int TMO = 200;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] data_in_1 = '0;
  logic [DW-1:0] data_in_2 = '0;
  logic [DW-1:0] data_out_1, data_out_2;
  logic [AW-1:0] addr_1 = '0;
  logic [AW-1:0] addr_2 = '0;
  logic          rw_1 = 1'b1, rw_2 = 1'b1, ce_1 = 1'b0, ce_2 = 1'b0;
  logic          pro_1, pro_2, RDY_1, RDY_2;
  wire  [DW-1:0] data_low;
  logic [AW-1:0] addr_low;
  logic          rw_low, ce_low;
  logic          RDY_low = 1'b0;

  // memory model state
  logic          mem_drv = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  int            mem_lat = 1;
  int            mem_cnt = 0;
  int            acc_cnt = 0;
  logic          rd_fixed_en = 1'b0;
  logic [DW-1:0] rd_fixed = '0;
  logic [AW+DW-1:0] wlog[$];

  int n_chk = 0;
  int n_err = 0;

  assign data_low = mem_drv ? mem_rdata : {DW{1'bz}};

  l2_mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .data_in_1  (data_in_1),
    .data_out_1 (data_out_1),
    .addr_1     (addr_1),
    .rw_1       (rw_1),
    .ce_1       (ce_1),
    .pro_1      (pro_1),
    .RDY_1      (RDY_1),
    .data_in_2  (data_in_2),
    .data_out_2 (data_out_2),
    .addr_2     (addr_2),
    .rw_2       (rw_2),
    .ce_2       (ce_2),
    .pro_2      (pro_2),
    .RDY_2      (RDY_2),
    .data_low   (data_low),
    .addr_low   (addr_low),
    .rw_low     (rw_low),
    .RDY_low    (RDY_low),
    .ce_low     (ce_low)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {8'h5A, a, 8'hC3, ~a};
  endfunction

  // Memory: raises RDY_low mem_lat falling edges after ce_low rises, holds it until ce_low drops
  always @(negedge clk) begin
    if (!ce_low) begin
      mem_cnt = 0;
      RDY_low = 1'b0;
      mem_drv = 1'b0;
    end else begin
      if (mem_cnt == 0) acc_cnt++;
      if (!RDY_low && mem_cnt >= mem_lat) begin
        RDY_low = 1'b1;
        if (rw_low) begin
          mem_drv   = 1'b1;
          mem_rdata = rd_fixed_en ? rd_fixed : mem_word(addr_low);
        end else begin
          wlog.push_back({addr_low, data_low});
        end
      end
      mem_cnt++;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, DW'(act), DW'(exp));
  endtask

  task automatic chk_rel(input string name);
    logic ok;
    ok = (data_low === {DW{1'bz}}) || (data_low === {DW{1'b0}});
    chk1(name, ok, 1'b1);
  endtask

  task automatic req(input int p, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 1) begin
      rw_1 = rw; addr_1 = a; data_in_1 = d; ce_1 = 1'b1;
    end else begin
      rw_2 = rw; addr_2 = a; data_in_2 = d; ce_2 = 1'b1;
    end
  endtask

  task automatic drop(input int p);
    if (p == 1) ce_1 = 1'b0;
    else        ce_2 = 1'b0;
  endtask

  task automatic wait_rdy(output int who, output int cyc);
    who = 0;
    cyc = 0;
    while (cyc < TMO && who == 0) begin
      @(posedge clk);
      #1;
      cyc++;
      if (RDY_1 && RDY_2) who = 3;
      else if (RDY_1)     who = 1;
      else if (RDY_2)     who = 2;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    ce_1 = 1'b0;
    ce_2 = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    int            port;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            lat;
    int            exp_cyc;
  } vec_t;

  vec_t vt[5];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [DW-1:0] exp_dout[1:2];
    logic [AW-1:0] ta[1:2];
    logic [DW-1:0] td[1:2];
    logic          rr[1:2];
    int            order[3];
    int            who, n, p, first, nreq, mask, acc0, wbase, wdone, last_m, exp_lat;
    logic          other_bad, got, bad;

    vt[0] = '{1, 1'b1, 24'hF50002, 64'h0,                64'h0123456789ABCDEF, 1, 3};
    vt[1] = '{2, 1'b0, 24'h7A2000, 64'hABABABAB37373737, 64'h0,                2, 4};
    vt[2] = '{2, 1'b1, 24'h000010, 64'h0,                64'hFEDCBA9876543210, 0, 3};
    vt[3] = '{1, 1'b0, 24'h800001, 64'h1122334455667788, 64'h0,                5, 7};
    vt[4] = '{1, 1'b1, 24'hFFFFFF, 64'h0,                64'h8000000000000001, 3, 5};

    exp_dout[1] = '0;
    exp_dout[2] = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk1("rst pro_1", pro_1, 1'b0);
    chk1("rst pro_2", pro_2, 1'b0);
    chk1("rst RDY_1", RDY_1, 1'b0);
    chk1("rst RDY_2", RDY_2, 1'b0);
    chk1("rst ce_low", ce_low, 1'b0);
    chk1("rst rw_low", rw_low, 1'b1);
    chk("rst addr_low", DW'(addr_low), '0);
    chk("rst data_out_1", data_out_1, '0);
    chk("rst data_out_2", data_out_2, '0);
    chk_rel("rst data_low released");
    @(negedge clk);
    reset = 1'b1;

    // tie from reset, port 1 re-requests as soon as it is released
    mem_lat = 1;
    rd_fixed_en = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    order = '{1, 2, 1};
`else
    order = '{1, 1, 2};
`endif
    @(negedge clk);
    ta[1] = 24'h100001;
    ta[2] = 24'h200002;
    req(1, 1'b1, ta[1], '0);
    req(2, 1'b1, ta[2], '0);
    for (int k = 0; k < 3; k++) begin
      wait_rdy(who, n);
      chk($sformatf("tie%0d winner", k), DW'(who), DW'(order[k]));
      p = order[k];
      exp_dout[p] = mem_word(ta[p]);
      chk($sformatf("tie%0d data_out_1", k), data_out_1, exp_dout[1]);
      chk($sformatf("tie%0d data_out_2", k), data_out_2, exp_dout[2]);
      @(negedge clk);
      drop(p);
      if (k == 0) begin
        @(posedge clk);
        @(negedge clk);
        ta[1] = 24'h300003;
        req(1, 1'b1, ta[1], '0);
      end
    end
    @(posedge clk);

    // table-driven single-port transactions
    for (int i = 0; i < 5; i++) begin
      p = vt[i].port;
      @(negedge clk);
      rd_fixed_en = 1'b1;
      rd_fixed = vt[i].rdata;
      mem_lat = vt[i].lat;
      wbase = wlog.size();
      req(p, vt[i].rw, vt[i].addr, vt[i].wdata);
      n = 0;
      other_bad = 1'b0;
      got = 1'b0;
      while (n < TMO && !got) begin
        @(posedge clk);
        #1;
        n++;
        if (n == 1) begin
          chk1($sformatf("v%0d pro", i), (p == 1) ? pro_1 : pro_2, 1'b1);
          chk1($sformatf("v%0d ce_low", i), ce_low, 1'b1);
          chk($sformatf("v%0d addr_low", i), DW'(addr_low), DW'(vt[i].addr));
          chk1($sformatf("v%0d rw_low", i), rw_low, vt[i].rw);
        end
        if (n == 2 && !vt[i].rw)
          chk($sformatf("v%0d write data_low", i), data_low, vt[i].wdata);
        if (p == 1) begin
          other_bad = other_bad | pro_2 | RDY_2;
          got = RDY_1;
        end else begin
          other_bad = other_bad | pro_1 | RDY_1;
          got = RDY_2;
        end
      end
      chk($sformatf("v%0d latency", i), DW'(n), DW'(vt[i].exp_cyc));
      if (vt[i].rw) exp_dout[p] = vt[i].rdata;
      else begin
        chk($sformatf("v%0d write count", i), DW'(wlog.size()), DW'(wbase + 1));
        if (wlog.size() > 0)
          chk($sformatf("v%0d write log", i), wlog[wlog.size()-1][DW-1:0], vt[i].wdata);
      end
      chk($sformatf("v%0d data_out_1", i), data_out_1, exp_dout[1]);
      chk($sformatf("v%0d data_out_2", i), data_out_2, exp_dout[2]);
      chk1($sformatf("v%0d other port quiet", i), other_bad, 1'b0);
      @(negedge clk);
      drop(p);
      @(posedge clk);
      #1;
      chk1($sformatf("v%0d RDY pulse ends", i), (p == 1) ? RDY_1 : RDY_2, 1'b0);
      chk1($sformatf("v%0d pro released", i), (p == 1) ? pro_1 : pro_2, 1'b0);
      @(posedge clk);
      #1;
      chk_rel($sformatf("v%0d data_low released", i));
    end

    // hold-off: port 1 keeps ce high after RDY_1, port 2 must wait
    rd_fixed_en = 1'b0;
    mem_lat = 1;
    @(negedge clk);
    ta[1] = 24'h123456;
    req(1, 1'b1, ta[1], '0);
    wait_rdy(who, n);
    chk("hold first winner", DW'(who), 64'd1);
    exp_dout[1] = mem_word(ta[1]);
    chk("hold data_out_1", data_out_1, exp_dout[1]);
    acc0 = acc_cnt;
    wbase = wlog.size();
    @(negedge clk);
    ta[2] = 24'h0ABCDE;
    td[2] = 64'hC0FFEE00C0FFEE00;
    req(2, 1'b0, ta[2], td[2]);
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (!pro_1 || pro_2 || ce_low || RDY_1 || RDY_2) bad = 1'b1;
    end
    chk1("hold bus frozen", bad, 1'b0);
    chk("hold no second access", DW'(acc_cnt), DW'(acc0));
    @(negedge clk);
    drop(1);
    wait_rdy(who, n);
    chk("hold then port 2", DW'(who), 64'd2);
    chk("hold write count", DW'(wlog.size()), DW'(wbase + 1));
    if (wlog.size() > 0) chk("hold write log", DW'(wlog[wlog.size()-1] >> DW), DW'(ta[2]));
    @(negedge clk);
    drop(2);
    @(posedge clk);

    // abort in WAIT: memory never answers
    mem_lat = 1000;
    @(negedge clk);
    req(1, 1'b1, 24'h00AB0C, '0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    drop(1);
    @(posedge clk);
    #1;
    chk1("abort ce_low", ce_low, 1'b0);
    chk1("abort pro_1", pro_1, 1'b0);
    bad = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (RDY_1 || RDY_2 || ce_low) bad = 1'b1;
    end
    chk1("abort no completion", bad, 1'b0);
    chk("abort data_out_1 kept", data_out_1, exp_dout[1]);

    // reset in the middle of a port 2 write
    @(negedge clk);
    req(2, 1'b0, 24'h7A2000, 64'hABABABAB37373737);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rstw data_low driven", data_low, 64'hABABABAB37373737);
    chk1("rstw pro_2 before", pro_2, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk_rel("rstw data_low released");
    chk1("rstw pro_2", pro_2, 1'b0);
    chk1("rstw ce_low", ce_low, 1'b0);
    chk1("rstw rw_low", rw_low, 1'b1);
    chk("rstw addr_low", DW'(addr_low), '0);
    chk("rstw data_out_1", data_out_1, '0);
    chk("rstw data_out_2", data_out_2, '0);
    exp_dout[1] = '0;
    exp_dout[2] = '0;
    @(negedge clk);
    drop(2);
    reset = 1'b1;
    mem_lat = 1;
    bad = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (RDY_2 || ce_low || pro_2) bad = 1'b1;
    end
    chk1("rstw not resumed", bad, 1'b0);

    // randomized traffic against an order/data reference model
    apply_reset();
    last_m = 2;
    rd_fixed_en = 1'b0;
    for (int it = 0; it < 40; it++) begin
      mask = int'($urandom_range(1, 3));
      @(negedge clk);
      mem_lat = int'($urandom_range(0, 4));
      wbase = wlog.size();
      wdone = 0;
      for (int q = 1; q <= 2; q++) begin
        if (mask[q-1]) begin
          rr[q] = 1'($urandom_range(0, 1));
          ta[q] = AW'($urandom);
          td[q] = {$urandom, $urandom};
          req(q, rr[q], ta[q], td[q]);
        end
      end
      if (mask == 3) begin
`ifdef ARB_ROUND_ROBIN_EN
        first = (last_m == 1) ? 2 : 1;
`else
        first = 1;
`endif
        nreq = 2;
      end else begin
        first = mask;
        nreq = 1;
      end
      for (int k = 0; k < nreq; k++) begin
        p = (k == 0) ? first : 3 - first;
        wait_rdy(who, n);
        chk($sformatf("r%0d.%0d winner", it, k), DW'(who), DW'(p));
        if (rr[p]) begin
          exp_dout[p] = mem_word(ta[p]);
        end else begin
          wdone++;
          chk($sformatf("r%0d.%0d write count", it, k), DW'(wlog.size()), DW'(wbase + wdone));
          if (wlog.size() > 0)
            chk($sformatf("r%0d.%0d write data", it, k), wlog[wlog.size()-1][DW-1:0], td[p]);
        end
        chk($sformatf("r%0d.%0d data_out_1", it, k), data_out_1, exp_dout[1]);
        chk($sformatf("r%0d.%0d data_out_2", it, k), data_out_2, exp_dout[2]);
        if (nreq == 1) begin
          exp_lat = (mem_lat + 2 > 3) ? mem_lat + 2 : 3;
          chk($sformatf("r%0d latency", it), DW'(n), DW'(exp_lat));
        end
        @(negedge clk);
        drop(p);
        last_m = p;
      end
      @(posedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
